// File: rtl/sid_bus_writer.sv
// SID register-write engine: FIFO-buffered (chip,addr,data) writes played onto a shared
// SID bus with phi2-aligned chip selects, plus SID_CLK generation and power-on reset hold.
`timescale 1ns/1ps
module sid_bus_writer #(
  parameter int CLK_DIV      = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int NUM_SIDS     = 2,
  parameter int RESET_CYCLES = 16
) (
  input  logic                          C6_CLK_8MHZ,
  input  logic                          RESET,
  input  logic                          WR_VALID,
  output logic                          WR_READY,
  input  logic [1:0]                    WR_CHIP,
  input  logic [4:0]                    WR_ADDR,
  input  logic [7:0]                    WR_DATA,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          BUSY,
  output logic                          WR_DONE,
  output logic                          WR_DROP,
  output logic                          SID_CLK,
  output logic                          SID_NOTRES,
  output logic [NUM_SIDS-1:0]           SID_NOTCS,
  output logic [4:0]                    SID_ADDR,
  output logic [7:0]                    SID_DATA
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int RST_W = $clog2(RESET_CYCLES + 1);

  localparam logic [1:0] ST_RST_HOLD = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_WRITE    = 2'd2;
  localparam logic [1:0] ST_GAP      = 2'd3;

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic             boundary;

  logic [1:0]       state;
  logic [RST_W-1:0] rst_cnt;

  logic [14:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_next;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  logic [14:0]      head;
  logic [1:0]       head_chip;
  logic [4:0]       head_addr;
  logic [7:0]       head_data;
  logic             chip_ok;

  always_comb begin
    div_next = div + DIV_W'(1);
    if (div == DIV_W'(CLK_DIV - 1)) begin
      div_next = '0;
    end
  end

  // A boundary is the edge that moves div from 0 to 1, one clock after phi2 falls.
  assign boundary = (div == '0);

  always_ff @(posedge C6_CLK_8MHZ) begin
    if (RESET) begin
      div     <= '0;
      SID_CLK <= 1'b0;
    end else begin
      div     <= div_next;
      SID_CLK <= (div_next >= DIV_W'(CLK_DIV / 2));
    end
  end

  assign head       = mem[rd_ptr];
  assign head_chip  = head[14:13];
  assign head_addr  = head[12:8];
  assign head_data  = head[7:0];
  assign chip_ok    = ({1'b0, head_chip} < 3'(NUM_SIDS));
  assign fifo_empty = (FIFO_LEVEL == '0);
  assign push       = WR_VALID && WR_READY;
  assign pop        = boundary && ((state == ST_IDLE) || (state == ST_GAP)) && !fifo_empty;
  assign BUSY       = !fifo_empty || (state != ST_IDLE);

  always_comb begin
    level_next = FIFO_LEVEL;
    if (push && !pop) begin
      level_next = FIFO_LEVEL + LVL_W'(1);
    end else if (!push && pop) begin
      level_next = FIFO_LEVEL - LVL_W'(1);
    end
  end

  always_ff @(posedge C6_CLK_8MHZ) begin
    if (push) begin
      mem[wr_ptr] <= {WR_CHIP, WR_ADDR, WR_DATA};
    end
  end

  // READY comes from last clock's level, so a full FIFO refuses a push even on a pop clock.
  always_ff @(posedge C6_CLK_8MHZ) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_LEVEL <= '0;
      WR_READY   <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      FIFO_LEVEL <= level_next;
      WR_READY   <= (level_next < LVL_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge C6_CLK_8MHZ) begin
    if (RESET) begin
      state      <= ST_RST_HOLD;
      rst_cnt    <= '0;
      SID_NOTRES <= 1'b0;
      SID_NOTCS  <= '1;
      SID_ADDR   <= '0;
      SID_DATA   <= '0;
      WR_DONE    <= 1'b0;
      WR_DROP    <= 1'b0;
    end else begin
      WR_DONE <= 1'b0;
      WR_DROP <= 1'b0;
      if (boundary) begin
        case (state)
          ST_RST_HOLD: begin
            if (rst_cnt == RST_W'(RESET_CYCLES)) begin
              SID_NOTRES <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              rst_cnt <= rst_cnt + RST_W'(1);
            end
          end
          // GAP ends at the same boundary that may start the next write.
          ST_IDLE, ST_GAP: begin
            state <= ST_IDLE;
            if (pop) begin
              if (chip_ok) begin
                SID_ADDR  <= head_addr;
                SID_DATA  <= head_data;
                SID_NOTCS <= ~(NUM_SIDS'(1) << head_chip);
                state     <= ST_WRITE;
              end else begin
                WR_DROP <= 1'b1;
              end
            end
          end
          ST_WRITE: begin
            SID_NOTCS <= '1;
            WR_DONE   <= 1'b1;
            state     <= ST_GAP;
          end
          default: begin
            state <= ST_RST_HOLD;
          end
        endcase
      end
    end
  end

  a_single_cs: assert property (@(posedge C6_CLK_8MHZ) disable iff (RESET) $onehot0(~SID_NOTCS));
  a_done_drop: assert property (@(posedge C6_CLK_8MHZ) disable iff (RESET) !(WR_DONE && WR_DROP));

endmodule

// File: tb/tb_sid_bus_writer.sv
// Directed self-checking bench for sid_bus_writer: reset hold, single write timing,
// FIFO fill/refuse/order, chip drop, reset mid-write and full-FIFO push/pop interplay.
`timescale 1ns/1ps
module tb_sid_bus_writer;

  logic       C6_CLK_8MHZ = 1'b0;
  logic       RESET = 1'b1;
  logic       WR_VALID = 1'b0;
  logic       WR_READY;
  logic [1:0] WR_CHIP = '0;
  logic [4:0] WR_ADDR = '0;
  logic [7:0] WR_DATA = '0;
  logic [4:0] FIFO_LEVEL;
  logic       BUSY;
  logic       WR_DONE;
  logic       WR_DROP;
  logic       SID_CLK;
  logic       SID_NOTRES;
  logic [1:0] SID_NOTCS;
  logic [4:0] SID_ADDR;
  logic [7:0] SID_DATA;

  sid_bus_writer #(
    .CLK_DIV(8), .FIFO_DEPTH(16), .NUM_SIDS(2), .RESET_CYCLES(16)
  ) dut (
    .C6_CLK_8MHZ(C6_CLK_8MHZ), .RESET(RESET),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .WR_CHIP(WR_CHIP), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .FIFO_LEVEL(FIFO_LEVEL), .BUSY(BUSY), .WR_DONE(WR_DONE), .WR_DROP(WR_DROP),
    .SID_CLK(SID_CLK), .SID_NOTRES(SID_NOTRES), .SID_NOTCS(SID_NOTCS),
    .SID_ADDR(SID_ADDR), .SID_DATA(SID_DATA)
  );

  always #5 C6_CLK_8MHZ = ~C6_CLK_8MHZ;

  typedef struct {
    int         start;
    logic [1:0] notcs;
    logic [4:0] addr;
    logic [7:0] data;
    int         len;
    bit         stable;
  } wr_t;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  wr_t wlog[$];
  int  done_cyc[$];
  int  drop_cyc[$];
  wr_t cur_w;
  bit  in_win = 1'b0;

  // Cycle index since the last reset edge; equals the expected divider phase.
  always @(posedge C6_CLK_8MHZ) cyc <= RESET ? 0 : cyc + 1;

  // Records every chip-select window and every DONE/DROP pulse, sampled mid-cycle.
  always @(negedge C6_CLK_8MHZ) begin
    if (SID_NOTCS != 2'b11) begin
      if (!in_win) begin
        in_win       = 1'b1;
        cur_w.start  = cyc;
        cur_w.notcs  = SID_NOTCS;
        cur_w.addr   = SID_ADDR;
        cur_w.data   = SID_DATA;
        cur_w.len    = 1;
        cur_w.stable = 1'b1;
      end else begin
        cur_w.len = cur_w.len + 1;
        if (SID_NOTCS !== cur_w.notcs || SID_ADDR !== cur_w.addr || SID_DATA !== cur_w.data)
          cur_w.stable = 1'b0;
      end
    end else if (in_win) begin
      in_win = 1'b0;
      wlog.push_back(cur_w);
    end
    if (WR_DONE) done_cyc.push_back(cyc);
    if (WR_DROP) drop_cyc.push_back(cyc);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge C6_CLK_8MHZ);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] chip,
                               input logic [4:0] addr, input logic [7:0] data);
    WR_VALID = valid;
    WR_CHIP  = chip;
    WR_ADDR  = addr;
    WR_DATA  = data;
    tick();
  endtask

  task automatic clearLogs();
    wlog.delete();
    done_cyc.delete();
    drop_cyc.delete();
  endtask

  task automatic doReset();
    WR_VALID = 1'b0;
    RESET    = 1'b1;
    tick();
    RESET = 1'b0;
    clearLogs();
  endtask

  task automatic waitWrites(input int n, input int bound, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (wlog.size() >= n) begin
        timeout = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic waitDone(input int n, input int bound, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (done_cyc.size() >= n) begin
        timeout = 1'b0;
        break;
      end
      tick();
    end
  endtask

  function automatic wr_t wAt(input int k);
    wr_t w;
    w.start  = -1;
    w.notcs  = 2'b11;
    w.addr   = '0;
    w.data   = '0;
    w.len    = 0;
    w.stable = 1'b0;
    if (k < wlog.size()) w = wlog[k];
    return w;
  endfunction

  initial begin
    bit to;
    int low, highs, rises, cs_bad, base;
    logic prev_clk;

    // Reset state and the 16-SID-cycle reset hold
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    clearLogs();
    checkOutput("rst_notres", SID_NOTRES, 0);
    checkOutput("rst_notcs", SID_NOTCS, 2'b11);
    checkOutput("rst_addr", SID_ADDR, 0);
    checkOutput("rst_data", SID_DATA, 0);
    checkOutput("rst_sidclk", SID_CLK, 0);
    checkOutput("rst_level", FIFO_LEVEL, 0);
    checkOutput("rst_ready", WR_READY, 1);
    checkOutput("rst_done", WR_DONE, 0);
    checkOutput("rst_drop", WR_DROP, 0);
    low = 0; highs = 0; rises = 0; cs_bad = 0; prev_clk = SID_CLK;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (SID_NOTRES) break;
      low++;
      if (SID_CLK) highs++;
      if (SID_CLK && !prev_clk) rises++;
      prev_clk = SID_CLK;
      if (SID_NOTCS != 2'b11) cs_bad++;
    end
    checkOutput("t1_notres_low_clocks", low, 128);
    checkOutput("t1_sidclk_high_clocks", highs, 64);
    checkOutput("t1_sidclk_rises", rises, 16);
    checkOutput("t1_cs_activity", cs_bad, 0);
    checkOutput("t1_release_cycle", cyc, 129);
    checkOutput("t1_addr", SID_ADDR, 0);
    checkOutput("t1_data", SID_DATA, 0);

    // Single write to chip 0
    clearLogs();
    applyStimulus(1'b1, 2'd0, 5'h18, 8'h1F);
    WR_VALID = 1'b0;
    checkOutput("t2_level_after_push", FIFO_LEVEL, 1);
    waitDone(1, 60, to);
    checkOutput("t2_wait_done", to, 0);
    repeat (24) tick();
    checkOutput("t2_num_writes", wlog.size(), 1);
    checkOutput("t2_cs_phase", wAt(0).start % 8, 1);
    checkOutput("t2_notcs", wAt(0).notcs, 2'b10);
    checkOutput("t2_addr", wAt(0).addr, 5'h18);
    checkOutput("t2_data", wAt(0).data, 8'h1F);
    checkOutput("t2_cs_len", wAt(0).len, 8);
    checkOutput("t2_stable", wAt(0).stable, 1);
    checkOutput("t2_done_count", done_cyc.size(), 1);
    checkOutput("t2_done_time", (done_cyc.size() > 0) ? done_cyc[0] : -1, wAt(0).start + 8);
    checkOutput("t2_busy_idle", BUSY, 0);

    // Fill the FIFO during reset hold, refuse the 17th, drain in order
    doReset();
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 2'(i % 2), 5'(i), 8'(8'hA0 + i));
    checkOutput("t3_ready_at_15", WR_READY, 1);
    applyStimulus(1'b1, 2'd1, 5'd15, 8'hAF);
    checkOutput("t3_ready_at_16", WR_READY, 0);
    checkOutput("t3_level_16", FIFO_LEVEL, 16);
    applyStimulus(1'b1, 2'd1, 5'h1E, 8'hEE);
    WR_VALID = 1'b0;
    checkOutput("t3_level_after_refuse", FIFO_LEVEL, 16);
    waitWrites(16, 600, to);
    checkOutput("t3_wait_writes", to, 0);
    repeat (40) tick();
    checkOutput("t3_num_writes", wlog.size(), 16);
    checkOutput("t3_first_start", wAt(0).start, 137);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("t3_addr_%0d", k), wAt(k).addr, 5'(k));
      checkOutput($sformatf("t3_data_%0d", k), wAt(k).data, 8'(8'hA0 + k));
      checkOutput($sformatf("t3_notcs_%0d", k), wAt(k).notcs, (k % 2 == 1) ? 2'b01 : 2'b10);
      if (k > 0) checkOutput($sformatf("t3_spacing_%0d", k), wAt(k).start - wAt(k - 1).start, 16);
    end
    checkOutput("t3_done_count", done_cyc.size(), 16);

    // Chips 0,1,3,1: chip 3 is dropped without bus activity
    clearLogs();
    applyStimulus(1'b1, 2'd0, 5'h01, 8'h11);
    applyStimulus(1'b1, 2'd1, 5'h02, 8'h22);
    applyStimulus(1'b1, 2'd3, 5'h03, 8'h33);
    applyStimulus(1'b1, 2'd1, 5'h04, 8'h44);
    WR_VALID = 1'b0;
    waitDone(3, 200, to);
    checkOutput("t4_wait_done", to, 0);
    repeat (30) tick();
    checkOutput("t4_num_writes", wlog.size(), 3);
    checkOutput("t4_w0_notcs", wAt(0).notcs, 2'b10);
    checkOutput("t4_w0_addr", wAt(0).addr, 5'h01);
    checkOutput("t4_w1_notcs", wAt(1).notcs, 2'b01);
    checkOutput("t4_w1_data", wAt(1).data, 8'h22);
    checkOutput("t4_w2_notcs", wAt(2).notcs, 2'b01);
    checkOutput("t4_w2_addr", wAt(2).addr, 5'h04);
    checkOutput("t4_w2_data", wAt(2).data, 8'h44);
    checkOutput("t4_drop_count", drop_cyc.size(), 1);
    base = (drop_cyc.size() > 0) ? drop_cyc[0] : -100;
    checkOutput("t4_drop_time", base, wAt(1).start + 16);
    checkOutput("t4_last_after_drop", wAt(2).start, base + 8);
    checkOutput("t4_done_count", done_cyc.size(), 3);

    // Reset while chip 1 is selected aborts the write
    clearLogs();
    applyStimulus(1'b1, 2'd1, 5'h05, 8'h55);
    applyStimulus(1'b1, 2'd1, 5'h06, 8'h66);
    applyStimulus(1'b1, 2'd1, 5'h07, 8'h77);
    WR_VALID = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (SID_NOTCS[1] == 1'b0) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    checkOutput("t5_wait_cs1", to, 0);
    checkOutput("t5_level_before", FIFO_LEVEL, 2);
    RESET = 1'b1;
    tick();
    checkOutput("t5_notcs", SID_NOTCS, 2'b11);
    checkOutput("t5_notres", SID_NOTRES, 0);
    checkOutput("t5_level", FIFO_LEVEL, 0);
    checkOutput("t5_done_now", WR_DONE, 0);
    RESET = 1'b0;
    repeat (30) tick();
    checkOutput("t5_done_count", done_cyc.size(), 0);
    checkOutput("t5_cs_len", wAt(0).len, 1);

    // Full FIFO with VALID held: pop frees a slot, push lands one clock later
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd0, 5'(i), 8'(i));
    WR_VALID = 1'b1;
    WR_CHIP  = 2'd1;
    WR_ADDR  = 5'h1F;
    WR_DATA  = 8'hEE;
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (FIFO_LEVEL != 5'd16) begin
        to = 1'b0;
        break;
      end
    end
    checkOutput("t6_wait_pop", to, 0);
    checkOutput("t6_pop_cycle", cyc, 137);
    checkOutput("t6_level_15", FIFO_LEVEL, 15);
    checkOutput("t6_ready_after_pop", WR_READY, 1);
    tick();
    WR_VALID = 1'b0;
    checkOutput("t6_level_16", FIFO_LEVEL, 16);
    checkOutput("t6_ready_full", WR_READY, 0);
    waitWrites(17, 600, to);
    checkOutput("t6_wait_writes", to, 0);
    repeat (40) tick();
    checkOutput("t6_num_writes", wlog.size(), 17);
    checkOutput("t6_w15_addr", wAt(15).addr, 5'd15);
    checkOutput("t6_last_addr", wAt(16).addr, 5'h1F);
    checkOutput("t6_last_data", wAt(16).data, 8'hEE);
    checkOutput("t6_last_notcs", wAt(16).notcs, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
